mem_fifo_ctrl: RTL and testbench
================================

MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 SHALL have parameter DW, default 20, data width matching the mem_twoport d/q ports.
REQ-002 SHALL have parameter AW, default 9, address width; depth is 2**AW (512).
REQ-003 SHALL have parameter AFULL, default 448, almost-full threshold in entries.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port push, input, 1, write request from the upstream producer.
REQ-007 SHALL have port push_data, input, DW, write data.
REQ-008 SHALL have port pop, input, 1, read request from the downstream consumer.
REQ-009 SHALL have port rd_data, output, DW, read data, equal to mem_q.
REQ-010 SHALL have port rd_valid, output, 1, rd_data is valid this cycle.
REQ-011 SHALL have port full, output, 1, count == 2**AW.
REQ-012 SHALL have port empty, output, 1, count == 0.
REQ-013 SHALL have port afull, output, 1, count >= AFULL.
REQ-014 SHALL have port count, output, AW+1, current occupancy, range 0..512.
REQ-015 SHALL have port mem_wa, output, AW, write address to mem_twoport wa, equal to wptr.
REQ-016 SHALL have port mem_ra, output, AW, read address to mem_twoport ra, equal to rptr.
REQ-017 SHALL have port mem_write, output, 1, write strobe to mem_twoport write.
REQ-018 SHALL have port mem_d, output, DW, write data to mem_twoport d, equal to push_data.
REQ-019 SHALL have port mem_q, input, DW, read data from mem_twoport q, registered with 1-cycle latency.
REQ-020 SHALL have port ovf, output, 1, sticky overflow flag (see Configuration).
REQ-021 SHALL have port udf, output, 1, sticky underflow flag (see Configuration).

Function
REQ-022 SHALL define push_acc = push & ~full, and pop_acc = pop & ~empty.
REQ-023 SHALL drive mem_write = push_acc combinationally, so the write commits at the same posedge.
REQ-024 SHALL increment wptr by 1 on push_acc and rptr by 1 on pop_acc, each modulo 2**AW (511 wraps to 0).
REQ-025 SHALL update count as +1 on push_acc only, -1 on pop_acc only, and unchanged when both or neither occur.
REQ-026 SHALL register rd_valid, asserting it exactly 1 cycle after a posedge with pop_acc; the data popped is the entry at the pre-increment rptr.
REQ-027 SHALL, when full, push, and pop occur together, reject the push and accept the pop; this avoids a read/write collision at the same address.
REQ-028 SHALL, when empty, push, and pop occur together, accept the push and ignore the pop; rd_valid stays low the next cycle.
REQ-029 SHALL have no bypass path; data written at edge N is first poppable at edge N+1.
REQ-030 SHALL derive full, empty, and afull combinationally from count.
REQ-031 SHALL preserve FIFO order across pointer wrap-around.

Reset
REQ-032 SHALL, while rst is high, asynchronously force wptr=0, rptr=0, count=0, rd_valid=0, ovf=0, udf=0.
REQ-033 SHALL hold reset outputs as empty=1, full=0, afull=0, mem_write=0 (push is ignored while rst is high), mem_wa=0, mem_ra=0.
REQ-034 SHALL, on reset asserted mid-operation, discard all stored entries without flushing memory contents; a pending rd_valid is cleared.
REQ-035 SHALL accept push and pop on the first posedge after rst deasserts.

Configuration
REQ-036 SHALL gate sticky error flags with macro MEM_FIFO_ERR_FLAGS_EN.
REQ-037 SHALL, with MEM_FIFO_ERR_FLAGS_EN defined, set ovf on any push & full and udf on any pop & empty, each holding until rst.
REQ-038 SHALL, without MEM_FIFO_ERR_FLAGS_EN, tie ovf and udf to 0 while keeping the ports present; all other behaviour is identical.

Verification
REQ-039 SHALL cover: after rst, push 512 words 512..1023, one every 5 cycles -> full=1 and afull=1 after the 512th, and count=512.
REQ-040 SHALL cover: from full, pop 512 words -> rd_data sequence 512..1023 with rd_valid 1 cycle after each pop, then empty=1.
REQ-041 SHALL cover: from full, assert push+pop for 1 cycle -> mem_write=0, count=511, wptr unchanged, and rd_data=oldest word.
REQ-042 SHALL cover: from empty, assert push+pop with push_data=0x0ABCD -> count=1, rd_valid=0 next cycle; a subsequent pop returns 0x0ABCD.
REQ-043 SHALL cover: 600 push/pop pairs spanning pointer wrap 511->0 -> data order preserved and count stays constant.
REQ-044 SHALL cover: with MEM_FIFO_ERR_FLAGS_EN, a push when full and a pop when empty -> ovf=1 and udf=1 sticky until rst; with rst mid-burst, count=0 and empty=1 immediately without waiting for clk.

Source files
------------

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: FIFO controller that drives an external registered two-port
// memory (mem_twoport). It keeps the write/read pointers and occupancy,
// produces the memory write strobe and addresses, and flags read data valid
// one cycle after an accepted pop, matching the memory's read latency.
// Optional feature: define MEM_FIFO_ERR_FLAGS_EN to enable sticky
// overflow (ovf) and underflow (udf) flags; otherwise both are tied low.
module mem_fifo_ctrl #(
  parameter int DW    = 20,
  parameter int AW    = 9,
  parameter int AFULL = 448
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic [AW:0]   count,
  output logic [AW-1:0] mem_wa,
  output logic [AW-1:0] mem_ra,
  output logic          mem_write,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0] DEPTH     = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AFULL_LVL = AFULL[AW:0];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          rdv;
  logic          push_acc;
  logic          pop_acc;

  // Status flags come straight from the occupancy counter.
  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);
  assign afull = (cnt >= AFULL_LVL);

  // A push is refused when full and a pop when empty; nothing is accepted
  // while reset is held, so the memory never sees a write during reset.
  assign push_acc = push & ~full & ~rst;
  assign pop_acc  = pop & ~empty & ~rst;

  assign mem_write = push_acc;
  assign mem_d     = push_data;
  assign mem_wa    = wptr;
  assign mem_ra    = rptr;
  assign rd_data   = mem_q;
  assign rd_valid  = rdv;
  assign count     = cnt;

  // Pointers advance on accepted operations and wrap naturally at the depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc)  rptr <= rptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Read data valid tracks the one-cycle registered read of the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdv <= 1'b0;
    else     rdv <= pop_acc;
  end

`ifdef MEM_FIFO_ERR_FLAGS_EN
  logic ovf_r;
  logic udf_r;

  // Sticky error flags: any attempted push while full or pop while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (push & full) ovf_r <= 1'b1;
      if (pop & empty) udf_r <= 1'b1;
    end
  end

  assign ovf = ovf_r;
  assign udf = udf_r;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: directed plus randomized stimulus against a queue-based
// reference FIFO, with a behavioural registered two-port memory attached.
module tb_mem_fifo_ctrl;

  localparam int DW    = 20;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int AFULL = 448;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          afull;
  logic [AW:0]   count;
  logic [AW-1:0] mem_wa;
  logic [AW-1:0] mem_ra;
  logic          mem_write;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;
  logic          ovf;
  logic          udf;

  logic [DW-1:0] memArr [DEPTH];

  logic [DW-1:0] modelQ[$];
  int            wrTotal = 0;
  int            rdTotal = 0;
  bit            expOvf = 1'b0;
  bit            expUdf = 1'b0;
  int            checks = 0;
  int            errors = 0;

  mem_fifo_ctrl #(.DW(DW), .AW(AW), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .afull(afull), .count(count), .mem_wa(mem_wa), .mem_ra(mem_ra),
    .mem_write(mem_write), .mem_d(mem_d), .mem_q(mem_q), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // Registered two-port memory: read-before-write, one cycle read latency.
  always @(posedge clk) begin
    if (mem_write) memArr[mem_wa] <= mem_d;
    mem_q <= memArr[mem_ra];
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState();
    int sz;
    sz = modelQ.size();
    checkOutput("count", 64'(count), 64'(sz));
    checkOutput("empty", 64'(empty), 64'(sz == 0));
    checkOutput("full", 64'(full), 64'(sz == DEPTH));
    checkOutput("afull", 64'(afull), 64'(sz >= AFULL));
    checkOutput("mem_wa", 64'(mem_wa), 64'(wrTotal % DEPTH));
    checkOutput("mem_ra", 64'(mem_ra), 64'(rdTotal % DEPTH));
    checkOutput("ovf", 64'(ovf), 64'(expOvf));
    checkOutput("udf", 64'(udf), 64'(expUdf));
  endtask

  task automatic applyStimulus(input bit p, input bit r, input logic [DW-1:0] d);
    bit            expPush;
    bit            expPop;
    logic [DW-1:0] expData;
    int            sz;
    push = p;
    pop = r;
    push_data = d;
    sz = modelQ.size();
    expPush = p && (sz < DEPTH);
    expPop = r && (sz > 0);
`ifdef MEM_FIFO_ERR_FLAGS_EN
    if (p && sz == DEPTH) expOvf = 1'b1;
    if (r && sz == 0) expUdf = 1'b1;
`endif
    #1;
    checkOutput("mem_write", 64'(mem_write), 64'(expPush));
    if (expPush) checkOutput("mem_d", 64'(mem_d), 64'(d));
    @(posedge clk);
    #1;
    expData = '0;
    if (expPop) begin
      expData = modelQ.pop_front();
      rdTotal++;
    end
    if (expPush) begin
      modelQ.push_back(d);
      wrTotal++;
    end
    checkOutput("rd_valid", 64'(rd_valid), 64'(expPop));
    if (expPop) checkOutput("rd_data", 64'(rd_data), 64'(expData));
    checkState();
  endtask

  task automatic modelReset();
    modelQ.delete();
    wrTotal = 0;
    rdTotal = 0;
    expOvf = 1'b0;
    expUdf = 1'b0;
  endtask

  // Directed sequence followed by random traffic and a mid-burst reset.
  initial begin
    logic [DW-1:0] d;

    $display("[TB] reset state");
    push = 1'b1;
    push_data = 20'h12345;
    #12;
    checkOutput("reset_mem_write", 64'(mem_write), 64'd0);
    checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
    checkState();
    @(negedge clk);
    rst = 1'b0;
    push = 1'b0;

    $display("[TB] fill 512 words, one every 5 cycles");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, DW'(512 + i));
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, '0);
    end
    checkOutput("filled_full", 64'(full), 64'd1);
    checkOutput("filled_afull", 64'(afull), 64'd1);
    checkOutput("filled_count", 64'(count), 64'd512);

    $display("[TB] drain 512 words");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, '0);
    checkOutput("drained_empty", 64'(empty), 64'd1);

    $display("[TB] push+pop while empty");
    applyStimulus(1'b1, 1'b1, 20'h0ABCD);
    checkOutput("empty_pp_count", 64'(count), 64'd1);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput("empty_pp_data", 64'(rd_data), 64'h0ABCD);

    $display("[TB] pop while empty");
    applyStimulus(1'b0, 1'b1, '0);

    $display("[TB] refill with random data, then push while full");
    for (int i = 0; i < DEPTH; i++) begin
      d = DW'($urandom);
      applyStimulus(1'b1, 1'b0, d);
    end
    applyStimulus(1'b1, 1'b0, 20'hFFFFF);

    $display("[TB] push+pop while full");
    applyStimulus(1'b1, 1'b1, 20'h55555);
    checkOutput("full_pp_count", 64'(count), 64'd511);

    $display("[TB] 600 push/pop pairs across pointer wrap");
    for (int i = 0; i < 600; i++) begin
      d = DW'($urandom);
      applyStimulus(1'b1, 1'b1, d);
    end
    checkOutput("pairs_count", 64'(count), 64'd511);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      d = DW'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
    end

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, DW'(i + 7));
    applyStimulus(1'b1, 1'b1, 20'h00777);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_count", 64'(count), 64'd0);
    checkOutput("async_empty", 64'(empty), 64'd1);
    checkOutput("async_rd_valid", 64'(rd_valid), 64'd0);
    checkOutput("async_mem_write", 64'(mem_write), 64'd0);
    checkState();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] traffic right after reset");
    applyStimulus(1'b1, 1'b1, 20'h00321);
    applyStimulus(1'b1, 1'b1, 20'h00654);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
